// File: rtl/jk_cmd_arbiter.sv
// jk_cmd_arbiter
//   Two-requester command arbiter driving a shared bank of WIDTH JK bits.
//   A request seen in IDLE moves the FSM to ISSUE for exactly one cycle.
//   During that cycle the winner's grant is high and j/k carry its command.
//   At the end of ISSUE the shadow state q takes the JK update.
//   Contention is settled round-robin with a 1-bit pointer by default.
//
// Configuration macro:
//   JK_ARB_FIXED_PRIO_EN -- when defined, requester 0 always wins contention
//                           and no pointer is built.
//
// Ports:
//   clk               single clock, rising edge
//   reset             asynchronous, active-low reset
//   req0/op0/mask0    requester 0 request, opcode (00 hold, 01 clr, 10 set,
//                     11 toggle) and bit select
//   req1/op1/mask1    requester 1, same encoding
//   gnt0/gnt1         one-cycle grant pulses (registered)
//   j/k               JK bank inputs, zero outside ISSUE (registered)
//   q                 shadow of the bank state
//   busy              high while in ISSUE
module jk_cmd_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] mask0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] mask1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             win1;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] mask_sel;

`ifndef JK_ARB_FIXED_PRIO_EN
  logic             ptr_q, ptr_d;
`endif

  // Winner select. Requester 1 wins when it is alone, or when both are
  // active and the pointer favours it.
`ifdef JK_ARB_FIXED_PRIO_EN
  assign win1 = req1 & ~req0;
`else
  assign win1 = req1 & (~req0 | ptr_q);
`endif

  assign op_sel   = win1 ? op1   : op0;
  assign mask_sel = win1 ? mask1 : mask0;

  // The latched command is held directly as j_q/k_q.
  // The grant flops carry the winner id.
  // Later changes on req/op/mask therefore cannot disturb an issued command.
  always_comb begin
    state_d = IDLE;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    busy_d  = 1'b0;
    j_d     = '0;
    k_d     = '0;
    q_d     = q_q;
`ifndef JK_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = ISSUE;
          busy_d  = 1'b1;
          gnt0_d  = ~win1;
          gnt1_d  = win1;
          j_d     = mask_sel & {WIDTH{op_sel[1]}};
          k_d     = mask_sel & {WIDTH{op_sel[0]}};
`ifndef JK_ARB_FIXED_PRIO_EN
          // Point at the requester that did not just win.
          ptr_d   = ~win1;
`endif
        end
      end
      ISSUE: begin
        // JK equation, applied as ISSUE ends.
        q_d     = (j_q & ~q_q) | (~k_q & q_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      j_q     <= '0;
      k_q     <= '0;
      q_q     <= '0;
`ifndef JK_ARB_FIXED_PRIO_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      j_q     <= j_d;
      k_q     <= k_d;
      q_q     <= q_d;
`ifndef JK_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = busy_q;
  assign j    = j_q;
  assign k    = k_q;
  assign q    = q_q;

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// tb_jk_cmd_arbiter
//   Directed bench for jk_cmd_arbiter (WIDTH=4).
//   Inputs change 1 time unit after a rising edge and outputs are sampled at
//   the same point. The next edge therefore samples the new inputs.
module tb_jk_cmd_arbiter;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         req0, req1;
  logic [1:0]   op0, op1;
  logic [W-1:0] mask0, mask1;
  logic         gnt0, gnt1, busy;
  logic [W-1:0] j, k, q;

  int tests = 0;
  int fails = 0;

  jk_cmd_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .op0   (op0),
    .mask0 (mask0),
    .req1  (req1),
    .op1   (op1),
    .mask1 (mask1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .j     (j),
    .k     (k),
    .q     (q),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_g0, exp_g1;
    reset = 1'b0;
    req0 = 1'b0; op0 = 2'b00; mask0 = '0;
    req1 = 1'b0; op1 = 2'b00; mask1 = '0;

    // Reset state.
    #12;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_q", q, 0);
    @(negedge clk) reset = 1'b1;

    // Set bits 0 and 2. The first edge after reset samples the request.
    req0 = 1'b1; op0 = 2'b10; mask0 = 4'b0101;
    tick();
    chk("set_gnt0", gnt0, 1);
    chk("set_gnt1", gnt1, 0);
    chk("set_j", j, 4'b0101);
    chk("set_k", k, 4'b0000);
    chk("set_busy", busy, 1);
    chk("set_q_pre", q, 4'b0000);
    req0 = 1'b0;
    tick();
    chk("set_gnt0_off", gnt0, 0);
    chk("set_busy_off", busy, 0);
    chk("set_j_idle", j, 0);
    chk("set_q", q, 4'b0101);

    // Toggle all bits from requester 1.
    req1 = 1'b1; op1 = 2'b11; mask1 = 4'b1111;
    tick();
    chk("tog_gnt1", gnt1, 1);
    chk("tog_gnt0", gnt0, 0);
    chk("tog_j", j, 4'b1111);
    chk("tog_k", k, 4'b1111);
    req1 = 1'b0;
    tick();
    chk("tog_q", q, 4'b1010);
    chk("tog_gnt1_off", gnt1, 0);

    // A clear with an empty mask is granted but leaves q alone.
    req0 = 1'b1; op0 = 2'b01; mask0 = 4'b0000;
    tick();
    chk("nop_gnt0", gnt0, 1);
    chk("nop_j", j, 0);
    chk("nop_k", k, 0);
    req0 = 1'b0;
    tick();
    chk("nop_q", q, 4'b1010);

    // Changing op/mask during ISSUE leaves the latched set command in force.
    req0 = 1'b1; op0 = 2'b10; mask0 = 4'b0101;
    tick();
    chk("lat_gnt0", gnt0, 1);
    op0 = 2'b01; mask0 = 4'b1111; req0 = 1'b0;
    tick();
    chk("lat_q", q, 4'b1111);

    // The last grant went to requester 0 alone, so the pointer favours
    // requester 1 under contention.
    req0 = 1'b1; req1 = 1'b1; op0 = 2'b00; op1 = 2'b00; mask0 = '0; mask1 = '0;
    tick();
`ifdef JK_ARB_FIXED_PRIO_EN
    chk("ptr_gnt0", gnt0, 1);
    chk("ptr_gnt1", gnt1, 0);
`else
    chk("ptr_gnt0", gnt0, 0);
    chk("ptr_gnt1", gnt1, 1);
`endif
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("ptr_q", q, 4'b1111);

    // Assert reset during ISSUE; the command is aborted.
    req0 = 1'b1; op0 = 2'b10; mask0 = 4'b1111;
    tick();
    chk("abt_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("abt_q", q, 0);
    chk("abt_gnt0", gnt0, 0);
    chk("abt_busy_rst", busy, 0);
    chk("abt_j", j, 0);
    req0 = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick();
    tick();
    chk("abt_q_after", q, 0);
    chk("abt_gnt0_after", gnt0, 0);

    // Both requesters held high from reset: grants alternate every 2 cycles.
    req0 = 1'b1; req1 = 1'b1; op0 = 2'b00; op1 = 2'b00;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_g0 = 1'b0;
      exp_g1 = 1'b0;
`ifdef JK_ARB_FIXED_PRIO_EN
      if (c % 2 == 0) exp_g0 = 1'b1;
`else
      if (c == 0 || c == 4) exp_g0 = 1'b1;
      if (c == 2 || c == 6) exp_g1 = 1'b1;
`endif
      chk($sformatf("rr_gnt0_c%0d", c), gnt0, exp_g0);
      chk($sformatf("rr_gnt1_c%0d", c), gnt1, exp_g1);
      chk($sformatf("rr_excl_c%0d", c), gnt0 & gnt1, 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    chk("end_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
